decode_stage_p: RTL and testbench

DECODE_STAGE_P -- requirements
Module: decode_stage_p

---
 rtl/decode_stage_p.sv | 232 +++++++++++++++++++++++
 tb/tb_decode_stage_p.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_p.sv
// RV32-subset decode stage: register file with write bypass, branch/jump resolution,
// load-use hazard detection and the D->E pipeline register. Define BRANCH_EXT_EN for BLT/BGE/BLTU/BGEU.
module decode_stage_p #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic            ForwardAD,
  input  logic            ForwardBD,
  input  logic            FlushE,
  output logic            StallD,
  output logic            PCSrcD,
  output logic [XLEN-1:0] PCBranchD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            ResultSrcE,
  output logic            MemWriteE,
  output logic            ALUsrcE,
  output logic            JumpE,
  output logic            ValidE,
  output logic [3:0]      ALUctrlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ExtImmE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] a0
);

  localparam int IDXW = $clog2(NREGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       reg_write;
    logic       result_src;
    logic       mem_write;
    logic       alu_src;
    logic       jump;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } e_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_ext;
  ctrl_t           ctrl_d;
  logic            uses_rs1, uses_rs2, is_lui, is_branch, is_jal, is_jalr, br_ok, br_taken;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rd1, rd2, src_a, src_b, jalr_sum;
  logic            wr_en;
  e_t              e_d, e_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  assign imm_i = XLEN'($signed(InstrD[31:20]));
  assign imm_s = XLEN'($signed({InstrD[31:25], InstrD[11:7]}));
  assign imm_b = XLEN'($signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({InstrD[31:12], 12'b0}));

`ifdef BRANCH_EXT_EN
  assign br_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
  assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    ctrl_d    = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    is_lui    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    imm_ext   = '0;
    case (opcode)
      OPC_LUI: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; is_lui = 1'b1; imm_ext = imm_u;
      end
      OPC_JAL: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; is_jal = 1'b1;
      end
      OPC_JALR: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; is_jalr = 1'b1; uses_rs1 = 1'b1; imm_ext = imm_i;
      end
      OPC_BRANCH: begin
        is_branch = br_ok; uses_rs1 = br_ok; uses_rs2 = br_ok;
      end
      OPC_LOAD: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.result_src = 1'b1; ctrl_d.alu_src = 1'b1;
        uses_rs1 = 1'b1; imm_ext = imm_i;
      end
      OPC_STORE: begin
        ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_ext = imm_s;
      end
      OPC_IMM: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; uses_rs1 = 1'b1; imm_ext = imm_i;
        ctrl_d.alu_ctrl  = (funct3 == 3'b101) ? {InstrD[30], funct3} : {1'b0, funct3};
      end
      OPC_OP: begin
        ctrl_d.reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl_d.alu_ctrl  = {InstrD[30], funct3};
      end
      default: ;
    endcase
  end

  // Same-cycle writeback is bypassed so the decoder never sees a stale value.
  assign wr_en = RegWriteW && (RdW != 5'd0) && (32'(RdW) < NREGS);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (Rs1D != 5'd0 && 32'(Rs1D) < NREGS)
      rd1 = (wr_en && RdW == Rs1D) ? ResultW : rf_q[Rs1D[IDXW-1:0]];
    if (Rs2D != 5'd0 && 32'(Rs2D) < NREGS)
      rd2 = (wr_en && RdW == Rs2D) ? ResultW : rf_q[Rs2D[IDXW-1:0]];
  end

  // NOTE: the register file is reset entry by entry because a0 must read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[RdW[IDXW-1:0]] <= ResultW;
    end
  end

  assign a0    = rf_q[10];
  assign src_a = ForwardAD ? ALUOutM : rd1;
  assign src_b = ForwardBD ? ALUOutM : rd2;

  always_comb begin
    br_taken = 1'b0;
    if (is_branch) begin
      case (funct3)
        3'b000:  br_taken = (src_a == src_b);
        3'b001:  br_taken = (src_a != src_b);
`ifdef BRANCH_EXT_EN
        3'b100:  br_taken = ($signed(src_a) <  $signed(src_b));
        3'b101:  br_taken = ($signed(src_a) >= $signed(src_b));
        3'b110:  br_taken = (src_a <  src_b);
        3'b111:  br_taken = (src_a >= src_b);
`endif
        default: br_taken = 1'b0;
      endcase
    end
  end

  assign jalr_sum = src_a + imm_i;

  always_comb begin
    PCBranchD = PCD + imm_b;
    if (is_jal)  PCBranchD = PCD + imm_j;
    if (is_jalr) PCBranchD = {jalr_sum[XLEN-1:1], 1'b0};
  end

  assign StallD = e_q.valid && e_q.ctrl.result_src && (e_q.rd != 5'd0) &&
                  ((uses_rs1 && e_q.rd == Rs1D) || (uses_rs2 && e_q.rd == Rs2D));
  assign PCSrcD = (br_taken || is_jal || is_jalr) && !StallD;

  // A flushed or stalled slot becomes an all-zero bubble, data included.
  always_comb begin
    e_d = '0;
    if (!(FlushE || StallD)) begin
      e_d.valid = 1'b1;
      e_d.ctrl  = ctrl_d;
      e_d.rd1   = is_lui ? '0 : rd1;
      e_d.rd2   = rd2;
      e_d.imm   = imm_ext;
      e_d.pc4   = PCD + XLEN'(4);
      e_d.rs1   = Rs1D;
      e_d.rs2   = Rs2D;
      e_d.rd    = InstrD[11:7];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  assign ValidE     = e_q.valid;
  assign RegWriteE  = e_q.ctrl.reg_write;
  assign ResultSrcE = e_q.ctrl.result_src;
  assign MemWriteE  = e_q.ctrl.mem_write;
  assign ALUsrcE    = e_q.ctrl.alu_src;
  assign JumpE      = e_q.ctrl.jump;
  assign ALUctrlE   = e_q.ctrl.alu_ctrl;
  assign RD1E       = e_q.rd1;
  assign RD2E       = e_q.rd2;
  assign ExtImmE    = e_q.imm;
  assign PCPlus4E   = e_q.pc4;
  assign Rs1E       = e_q.rs1;
  assign Rs2E       = e_q.rs2;
  assign RdE        = e_q.rd;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed self-checking bench for decode_stage_p: decode table plus hazard, bypass,
// forwarding, jump and optional extended-branch sequences.
module tb_decode_stage_p;

  localparam int XLEN = 32;
`ifdef BRANCH_EXT_EN
  localparam logic EXT = 1'b1;
`else
  localparam logic EXT = 1'b0;
`endif

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_JALR = 7'b1100111, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_IMM = 7'b0010011;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] InstrD;
  logic [XLEN-1:0] PCD, ResultW, ALUOutM;
  logic RegWriteW, ForwardAD, ForwardBD, FlushE;
  logic [4:0] RdW;
  logic StallD, PCSrcD, RegWriteE, ResultSrcE, MemWriteE, ALUsrcE, JumpE, ValidE;
  logic [XLEN-1:0] PCBranchD, RD1E, RD2E, ExtImmE, PCPlus4E, a0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [3:0] ALUctrlE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_p #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .FlushE(FlushE), .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .Rs1D(Rs1D),
    .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ALUsrcE(ALUsrcE), .JumpE(JumpE), .ValidE(ValidE), .ALUctrlE(ALUctrlE), .RD1E(RD1E),
    .RD2E(RD2E), .ExtImmE(ExtImmE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .a0(a0)
  );

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  ctrl;   // {valid, regwrite, resultsrc, memwrite, alusrc, jump, aluctrl[3:0]}
    logic [31:0] imm;
    logic [31:0] rd1;
    logic        pcsrc;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] e_ctrl();
    return {ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUsrcE, JumpE, ALUctrlE};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    InstrD = 32'h0; RegWriteW = 1'b1; RdW = idx; ResultW = val;
    tick();
    RegWriteW = 1'b0;
  endtask

  initial begin
    // Decode table, evaluated with x1=0x203, x2=3, PCD=0x100.
    vecs[0]  = '{enc_r(7'h00, 2, 1, 3'b000, 6),         10'b1100000000, 32'h0,        32'h203, 1'b0, 32'h0};
    vecs[1]  = '{enc_r(7'h20, 2, 1, 3'b000, 6),         10'b1100001000, 32'h0,        32'h203, 1'b0, 32'h0};
    vecs[2]  = '{enc_i(12'hFFF, 1, 3'b000, 6, OPC_IMM), 10'b1100100000, 32'hFFFFFFFF, 32'h203, 1'b0, 32'h0};
    vecs[3]  = '{enc_i(12'h403, 1, 3'b101, 6, OPC_IMM), 10'b1100101101, 32'h403,      32'h203, 1'b0, 32'h0};
    vecs[4]  = '{enc_i(12'h400, 1, 3'b100, 6, OPC_IMM), 10'b1100100100, 32'h400,      32'h203, 1'b0, 32'h0};
    vecs[5]  = '{enc_i(12'h008, 1, 3'b010, 9, OPC_LOAD),10'b1110100000, 32'h8,        32'h203, 1'b0, 32'h0};
    vecs[6]  = '{enc_s(12'hFFC, 2, 1, 3'b010),          10'b1001100000, 32'hFFFFFFFC, 32'h203, 1'b0, 32'h0};
    vecs[7]  = '{{20'h80008, 5'd6, OPC_LUI},            10'b1100100000, 32'h80008000, 32'h0,   1'b0, 32'h0};
    vecs[8]  = '{32'h0000000F,                          10'b1000000000, 32'h0,        32'h0,   1'b0, 32'h0};
    vecs[9]  = '{enc_j(21'h8, 1),                       10'b1100010000, 32'h0,        32'h0,   1'b1, 32'h108};
    vecs[10] = '{enc_b(13'h1FF8, 1, 1, 3'b000),         10'b1000000000, 32'h0,        32'h203, 1'b1, 32'hF8};
    vecs[11] = '{enc_b(13'd16, 2, 1, 3'b001),           10'b1000000000, 32'h0,        32'h203, 1'b1, 32'h110};

    // Reset: a pending write and a valid instruction must both be ignored.
    rst_n = 1'b0; PCD = 32'h100; ALUOutM = '0; ForwardAD = 1'b0; ForwardBD = 1'b0; FlushE = 1'b0;
    InstrD = enc_r(7'h00, 2, 1, 3'b000, 6); RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'h77;
    tick(); tick();
    check("rst_ctrl", 64'(e_ctrl()), 64'h0);
    check("rst_rd1", 64'(RD1E), 64'h0);
    check("rst_pc4", 64'(PCPlus4E), 64'h0);
    check("rst_rde", 64'(RdE), 64'h0);
    check("rst_a0", 64'(a0), 64'h0);
    check("rst_rs1d", 64'(Rs1D), 64'h1);
    rst_n = 1'b1;
    wr(5'd10, 32'hAA);
    check("a0_write", 64'(a0), 64'hAA);

    // Write-read bypass, then the stored value, then x0 write ignored.
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h1234; InstrD = enc_r(7'h00, 0, 5, 3'b000, 6);
    tick();
    check("bypass_rd1", 64'(RD1E), 64'h1234);
    RegWriteW = 1'b0;
    tick();
    check("stored_rd1", 64'(RD1E), 64'h1234);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h55; InstrD = enc_r(7'h00, 0, 0, 3'b000, 6);
    tick();
    check("x0_rd1", 64'(RD1E), 64'h0);
    RegWriteW = 1'b0;

    // Decode table.
    wr(5'd1, 32'h203);
    wr(5'd2, 32'h3);
    PCD = 32'h100;
    for (int i = 0; i < 12; i++) begin
      InstrD = vecs[i].instr;
      #1;
      check($sformatf("v%0d_pcsrc", i), 64'(PCSrcD), 64'(vecs[i].pcsrc));
      if (vecs[i].pcsrc) check($sformatf("v%0d_tgt", i), 64'(PCBranchD), 64'(vecs[i].tgt));
      tick();
      check($sformatf("v%0d_ctrl", i), 64'(e_ctrl()), 64'(vecs[i].ctrl));
      check($sformatf("v%0d_imm", i), 64'(ExtImmE), 64'(vecs[i].imm));
      check($sformatf("v%0d_rd1", i), 64'(RD1E), 64'(vecs[i].rd1));
      check($sformatf("v%0d_pc4", i), 64'(PCPlus4E), 64'h104);
    end

    // Flush inserts a bubble.
    FlushE = 1'b1; InstrD = enc_r(7'h00, 2, 1, 3'b000, 6);
    tick();
    check("flush_ctrl", 64'(e_ctrl()), 64'h0);
    FlushE = 1'b0;

    // BNE with operand forwarding.
    wr(5'd1, 32'h3);
    wr(5'd2, 32'h3);
    ALUOutM = 32'h3; ForwardAD = 1'b1; PCD = 32'h100; InstrD = enc_b(13'd16, 2, 1, 3'b001);
    #1;
    check("bne_eq", 64'(PCSrcD), 64'h0);
    wr(5'd2, 32'h4);
    InstrD = enc_b(13'd16, 2, 1, 3'b001);
    #1;
    check("bne_ne", 64'(PCSrcD), 64'h1);
    check("bne_tgt", 64'(PCBranchD), 64'h110);
    ALUOutM = 32'h4;
    #1;
    check("bne_fwd_a", 64'(PCSrcD), 64'h0);
    ForwardAD = 1'b0; ForwardBD = 1'b1; ALUOutM = 32'h3;
    #1;
    check("bne_fwd_b", 64'(PCSrcD), 64'h0);
    ForwardBD = 1'b0;

    // Load-use stall and re-evaluation.
    wr(5'd1, 32'h10);
    InstrD = enc_i(12'h0, 1, 3'b010, 7, OPC_LOAD);
    tick();
    InstrD = enc_r(7'h00, 1, 7, 3'b000, 8);
    #1;
    check("lu_stall", 64'(StallD), 64'h1);
    check("lu_pcsrc", 64'(PCSrcD), 64'h0);
    tick();
    check("lu_bubble", 64'(e_ctrl()), 64'h0);
    check("lu_release", 64'(StallD), 64'h0);
    tick();
    check("lu_capture", 64'({ValidE, RegWriteE, RdE}), 64'({1'b1, 1'b1, 5'd8}));
    InstrD = enc_i(12'h0, 1, 3'b010, 7, OPC_LOAD);
    tick();
    InstrD = enc_b(13'd8, 7, 7, 3'b000);
    #1;
    check("lu_br_stall", 64'(StallD), 64'h1);
    check("lu_br_pcsrc", 64'(PCSrcD), 64'h0);
    tick();
    check("lu_br_taken", 64'(PCSrcD), 64'h1);
    InstrD = enc_i(12'h0, 1, 3'b010, 0, OPC_LOAD);
    tick();
    InstrD = enc_r(7'h00, 1, 0, 3'b000, 8);
    #1;
    check("lu_x0", 64'(StallD), 64'h0);
    InstrD = enc_i(12'h0, 1, 3'b010, 7, OPC_LOAD);
    tick();
    InstrD = {20'h00038, 5'd7, OPC_LUI};
    #1;
    check("lu_lui", 64'(StallD), 64'h0);
    tick();

    // JALR target alignment.
    wr(5'd1, 32'h203);
    PCD = 32'h40; InstrD = enc_i(12'd2, 1, 3'b000, 5, OPC_JALR);
    #1;
    check("jalr_pcsrc", 64'(PCSrcD), 64'h1);
    check("jalr_tgt", 64'(PCBranchD), 64'h204);
    tick();
    check("jalr_jump", 64'(JumpE), 64'h1);
    check("jalr_pc4", 64'(PCPlus4E), 64'h44);

    // Extended branches: x1=-1, x2=1.
    wr(5'd1, 32'hFFFFFFFF);
    wr(5'd2, 32'h1);
    PCD = 32'h100; InstrD = enc_b(13'd16, 2, 1, 3'b100);
    #1;
    check("blt", 64'(PCSrcD), 64'(EXT));
    tick();
    check("blt_ctrl", 64'(e_ctrl()), 64'h200);
    InstrD = enc_b(13'd16, 2, 1, 3'b110);
    #1;
    check("bltu", 64'(PCSrcD), 64'h0);
    InstrD = enc_b(13'd16, 2, 1, 3'b101);
    #1;
    check("bge", 64'(PCSrcD), 64'h0);
    InstrD = enc_b(13'd16, 2, 1, 3'b111);
    #1;
    check("bgeu", 64'(PCSrcD), 64'(EXT));
    if (EXT) check("bgeu_tgt", 64'(PCBranchD), 64'h110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
